// File: rtl/trace_frontend_mux.sv
// Trace-port front end: registers TRACEDATA/userio pins, remaps lanes per board revision,
// handles port width / lane reversal / SWO selection, reconfiguration flush, activity and heartbeat.
module trace_frontend_mux #(
  parameter int unsigned pTRACE_WIDTH    = 4,
  parameter int unsigned pUSERIO_WIDTH   = 4,
  parameter int unsigned pFLUSH_CYCLES   = 4,
  parameter int unsigned pSTRETCH_BITS   = 16,
  parameter int unsigned pHEARTBEAT_BITS = 23
) (
  input  logic                     trace_clk,
  input  logic                     reset,
  input  logic [pTRACE_WIDTH-1:0]  I_tracedata,
  input  logic [pUSERIO_WIDTH-1:0] I_userio_d,
  input  logic [3:0]               I_board_rev,
  input  logic                     I_reverse,
  input  logic [1:0]               I_port_width,
  input  logic                     I_cfg_load,
  output logic [pTRACE_WIDTH-1:0]  O_trace_data,
  output logic                     O_swo,
  output logic                     O_valid,
  output logic                     O_cfg_busy,
  output logic                     O_activity,
  output logic                     O_heartbeat
);

  localparam int unsigned FlushBits = $clog2(pFLUSH_CYCLES + 1);
  localparam logic [FlushBits-1:0] FlushInit = FlushBits'(pFLUSH_CYCLES);
  localparam logic [3:0] RevSwapped   = 4'd3;
  localparam logic [3:0] RevDefault   = 4'd4;
  localparam logic [1:0] WidthDefault = 2'd2;

  // Shadow configuration
  logic [3:0] rev_q;
  logic       reverse_q;
  logic [1:0] width_q;

  // Pipeline
  logic [pTRACE_WIDTH-1:0] s1_td_q;
  logic [pTRACE_WIDTH-1:0] s1_prev_q;
  logic [2:0]              u_meta_q;
  logic [2:0]              u_sync_q;
  logic [pTRACE_WIDTH-1:0] trace_data_q;
  logic                    swo_q;

  // Counters and status
  logic [FlushBits-1:0]       flush_cnt_q;
  logic                       valid_q;
  logic [pSTRETCH_BITS-1:0]   stretch_q;
  logic                       activity_q;
  logic [pHEARTBEAT_BITS-1:0] hb_q;

  // Combinational
  logic [pTRACE_WIDTH-1:0] lane_mask;
  logic [pTRACE_WIDTH-1:0] lanes_map;
  logic [pTRACE_WIDTH-1:0] lanes_rev;
  logic [pTRACE_WIDTH-1:0] lanes_out;
  logic [pTRACE_WIDTH-1:0] toggles;
  logic                    swo_sel;
  logic                    userio_unused;

  // Only userio[3:1] are consumed; bit 0 and any extra header pins are spare.
  assign userio_unused = ^I_userio_d;

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      rev_q     <= RevDefault;
      reverse_q <= 1'b0;
      width_q   <= WidthDefault;
    end else if (I_cfg_load) begin
      rev_q     <= I_board_rev;
      reverse_q <= I_reverse;
      width_q   <= I_port_width;
    end
  end

  // Width code 3 is reserved and behaves as two lanes.
  always_comb begin
    lane_mask = '0;
    case (width_q)
      2'd0:    lane_mask[0]   = 1'b1;
      2'd2:    lane_mask[3:0] = 4'hF;
      default: lane_mask[1:0] = 2'b11;
    endcase
  end

  always_comb begin
    lanes_map = s1_td_q;
    if (rev_q == RevSwapped) begin
      lanes_map[3:0] = {s1_td_q[3], s1_td_q[1], s1_td_q[2], u_sync_q[2]};
    end
    lanes_rev = lanes_map;
    if (reverse_q) begin
      case (width_q)
        2'd0:    lanes_rev = lanes_map;
        2'd2:    lanes_rev[3:0] = {lanes_map[0], lanes_map[1], lanes_map[2], lanes_map[3]};
        default: lanes_rev[1:0] = {lanes_map[0], lanes_map[1]};
      endcase
    end
    lanes_out = lanes_rev & lane_mask;
  end

  assign swo_sel = (rev_q == RevSwapped) ? u_sync_q[0] : u_sync_q[1];
  assign toggles = (s1_td_q ^ s1_prev_q) & lane_mask;

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      s1_td_q      <= '0;
      s1_prev_q    <= '0;
      u_meta_q     <= '0;
      u_sync_q     <= '0;
      trace_data_q <= '0;
      swo_q        <= 1'b0;
    end else begin
      s1_td_q      <= I_tracedata;
      s1_prev_q    <= s1_td_q;
      u_meta_q     <= I_userio_d[3:1];
      u_sync_q     <= u_meta_q;
      trace_data_q <= lanes_out;
      swo_q        <= swo_sel;
    end
  end

  // A load always restarts the flush, even when it lands on the final decrement.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      flush_cnt_q <= FlushInit;
      valid_q     <= 1'b0;
    end else if (I_cfg_load) begin
      flush_cnt_q <= FlushInit;
      valid_q     <= 1'b0;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_q <= flush_cnt_q - FlushBits'(1);
      if (flush_cnt_q == FlushBits'(1)) begin
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      stretch_q  <= '0;
      activity_q <= 1'b0;
    end else begin
      if (|toggles) begin
        stretch_q <= '1;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - pSTRETCH_BITS'(1);
      end
      activity_q <= (stretch_q != '0);
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_q + pHEARTBEAT_BITS'(1);
    end
  end

  assign O_trace_data = trace_data_q;
  assign O_swo        = swo_q;
  assign O_valid      = valid_q;
  assign O_cfg_busy   = ~valid_q;
  assign O_activity   = activity_q;
  assign O_heartbeat  = hb_q[pHEARTBEAT_BITS-1];

endmodule

// File: tb/tb_trace_frontend_mux.sv
// Self-checking bench for trace_frontend_mux: vector table, hand sequences for flush/SWO/activity,
// and random stimulus against a history-based reference model.
module tb_trace_frontend_mux;

  localparam int TW = 4;
  localparam int UW = 4;
  localparam int FL = 4;
  localparam int SB = 16;
  localparam int HB = 8;

  logic          trace_clk = 1'b0;
  logic          reset;
  logic [TW-1:0] tracedata;
  logic [UW-1:0] userio;
  logic [3:0]    board_rev;
  logic          reverse;
  logic [1:0]    port_width;
  logic          cfg_load;
  logic [TW-1:0] o_trace_data;
  logic          o_swo, o_valid, o_cfg_busy, o_activity, o_heartbeat;

  always #5 trace_clk = ~trace_clk;

  trace_frontend_mux #(
    .pTRACE_WIDTH   (TW),
    .pUSERIO_WIDTH  (UW),
    .pFLUSH_CYCLES  (FL),
    .pSTRETCH_BITS  (SB),
    .pHEARTBEAT_BITS(HB)
  ) dut (
    .trace_clk   (trace_clk),
    .reset       (reset),
    .I_tracedata (tracedata),
    .I_userio_d  (userio),
    .I_board_rev (board_rev),
    .I_reverse   (reverse),
    .I_port_width(port_width),
    .I_cfg_load  (cfg_load),
    .O_trace_data(o_trace_data),
    .O_swo       (o_swo),
    .O_valid     (o_valid),
    .O_cfg_busy  (o_cfg_busy),
    .O_activity  (o_activity),
    .O_heartbeat (o_heartbeat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: input histories, shadow config and event timestamps.
  int         edge_no = 0;
  logic [3:0] td_h1, td_h2, u_h1, u_h2;
  logic [3:0] sh_rev;
  logic       sh_rv;
  logic [1:0] sh_w;
  int         last_evt, last_tog, hb;
  bit         has_tog = 1'b0;
  bit         model_on = 1'b0;
  logic [3:0] e_td;
  logic       e_swo, e_valid, e_act, e_hb;

  typedef struct {
    logic [3:0] rev;
    logic       rv;
    logic [1:0] w;
    logic [3:0] td;
    logic       u3;
    logic [3:0] exp_td;
  } vec_t;
  vec_t vecs[13];

  function automatic int lanes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd2) ? 4 : 2;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] w);
    return 4'((1 << lanes(w)) - 1);
  endfunction

  function automatic logic [3:0] remap(input logic [3:0] td, input logic u3,
                                       input logic [3:0] rev, input logic rv,
                                       input logic [1:0] w);
    int n;
    logic [3:0] l, r;
    n = lanes(w);
    l = (rev == 4'd3) ? {td[3], td[1], td[2], u3} : td;
    r = l;
    if (rv) for (int i = 0; i < n; i++) r[i] = l[n-1-i];
    for (int i = 0; i < 4; i++) if (i >= n) r[i] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic tick();
    @(posedge trace_clk);
    edge_no++;
    if (reset) begin
      sh_rev = 4'd4; sh_rv = 1'b0; sh_w = 2'd2;
      td_h1 = '0; td_h2 = '0; u_h1 = '0; u_h2 = '0;
      last_evt = edge_no; has_tog = 1'b0; hb = 0;
      e_td = '0; e_swo = 1'b0; e_valid = 1'b0; e_act = 1'b0;
      model_on = 1'b1;
    end else begin
      e_td  = remap(td_h1, u_h2[3], sh_rev, sh_rv, sh_w);
      e_swo = (sh_rev == 4'd3) ? u_h2[1] : u_h2[2];
      e_act = has_tog && ((edge_no - 1 - last_tog) < (1 << SB) - 1);
      if (((td_h1 ^ td_h2) & lane_mask(sh_w)) != 4'd0) begin
        has_tog  = 1'b1;
        last_tog = edge_no;
      end
      hb = (hb + 1) % (1 << HB);
      if (cfg_load) begin
        sh_rev = board_rev; sh_rv = reverse; sh_w = port_width;
        last_evt = edge_no;
      end
      e_valid = (edge_no - last_evt) >= FL;
      td_h2 = td_h1; td_h1 = tracedata; u_h2 = u_h1; u_h1 = userio;
    end
    e_hb = 1'((hb >> (HB - 1)) & 1);
    #1;
    if (model_on) begin
      chk("m_trace_data", o_trace_data, e_td);
      chk("m_swo", o_swo, e_swo);
      chk("m_valid", o_valid, e_valid);
      chk("m_cfg_busy", o_cfg_busy, !e_valid);
      chk("m_activity", o_activity, e_act);
      chk("m_heartbeat", o_heartbeat, e_hb);
    end
  endtask

  task automatic load_cfg(input logic [3:0] rev, input logic rv, input logic [1:0] w);
    board_rev = rev; reverse = rv; port_width = w;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    int n_low, n_high;
    bit seen;
    vecs[0]  = '{4'd4, 1'b0, 2'd2, 4'hA,    1'b0, 4'hA};
    vecs[1]  = '{4'd3, 1'b0, 2'd2, 4'b1010, 1'b1, 4'b1101};
    vecs[2]  = '{4'd3, 1'b1, 2'd2, 4'b1010, 1'b1, 4'b1011};
    vecs[3]  = '{4'd3, 1'b0, 2'd2, 4'b1000, 1'b0, 4'b1000};
    vecs[4]  = '{4'd3, 1'b1, 2'd2, 4'b1000, 1'b0, 4'b0001};
    vecs[5]  = '{4'd4, 1'b1, 2'd0, 4'hF,    1'b0, 4'h1};
    vecs[6]  = '{4'd4, 1'b1, 2'd1, 4'b0001, 1'b0, 4'b0010};
    vecs[7]  = '{4'd4, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0011};
    vecs[8]  = '{4'd4, 1'b0, 2'd3, 4'b0110, 1'b0, 4'b0010};
    vecs[9]  = '{4'd4, 1'b1, 2'd3, 4'b0110, 1'b0, 4'b0001};
    vecs[10] = '{4'd3, 1'b0, 2'd1, 4'b0100, 1'b1, 4'b0011};
    vecs[11] = '{4'd3, 1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000};
    vecs[12] = '{4'd4, 1'b1, 2'd2, 4'b0001, 1'b1, 4'b1000};

    reset = 1'b1; tracedata = '0; userio = '0;
    board_rev = 4'd4; reverse = 1'b0; port_width = 2'd2; cfg_load = 1'b0;

    // Reset state, then data latency and flush release timing.
    tick(); tick();
    chk("rst_trace_data", o_trace_data, 4'h0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_cfg_busy", o_cfg_busy, 1'b1);
    chk("rst_activity", o_activity, 1'b0);
    chk("rst_heartbeat", o_heartbeat, 1'b0);
    reset = 1'b0;
    tracedata = 4'hA;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t1_valid_rise", o_valid, (k == 4));
      if (k == 2) chk("t1_data_latency", o_trace_data, 4'hA);
    end

    foreach (vecs[i]) begin
      load_cfg(vecs[i].rev, vecs[i].rv, vecs[i].w);
      tracedata = vecs[i].td;
      userio = {vecs[i].u3, 3'($urandom)};
      repeat (4) tick();
      chk("vec_trace_data", o_trace_data, vecs[i].exp_td);
      chk("vec_valid", o_valid, 1'b1);
    end

    // Second load two cycles after the first restarts the flush.
    n_low = 0;
    for (int k = 0; k < 20; k++) begin
      cfg_load = (k == 0 || k == 2);
      tick();
      if (o_valid) break;
      n_low++;
    end
    cfg_load = 1'b0;
    chk("t4_restart_low_cycles", n_low, 6);

    // Load on the 1 -> 0 decrement keeps O_valid low.
    n_low = 0;
    for (int k = 0; k < 20; k++) begin
      cfg_load = (k == 0 || k == 4);
      tick();
      if (o_valid) break;
      n_low++;
    end
    cfg_load = 1'b0;
    chk("t4_coincident_low_cycles", n_low, 8);

    // SWO source selection and latency.
    userio = '0;
    load_cfg(4'd4, 1'b0, 2'd2);
    repeat (4) tick();
    for (int k = 1; k <= 5; k++) begin
      userio = (k == 1) ? 4'b0100 : 4'b0000;
      tick();
      chk("t6_swo_rev4", o_swo, (k == 3));
    end
    load_cfg(4'd3, 1'b0, 2'd2);
    repeat (4) tick();
    for (int k = 1; k <= 5; k++) begin
      userio = (k == 1) ? 4'b0100 : 4'b0000;
      tick();
      chk("t6_swo_rev3_ignores_u2", o_swo, 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      userio = (k == 1) ? 4'b0010 : 4'b0000;
      tick();
      chk("t6_swo_rev3_u1", o_swo, (k == 3));
    end

    // Random traffic with occasional loads and resets.
    for (int k = 0; k < 2000; k++) begin
      reset      = ($urandom_range(0, 299) == 0);
      tracedata  = 4'($urandom);
      userio     = 4'($urandom);
      cfg_load   = ($urandom_range(0, 11) == 0);
      board_rev  = ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom);
      reverse    = 1'($urandom);
      port_width = 2'($urandom);
      tick();
    end
    cfg_load = 1'b0;

    // Activity: masked lanes ignored, one toggle stretches for 2^SB-1 cycles.
    reset = 1'b1; tracedata = '0; userio = '0;
    tick(); tick();
    reset = 1'b0;
    load_cfg(4'd4, 1'b0, 2'd0);
    for (int k = 0; k < 20; k++) begin
      tracedata = k[0] ? 4'b1000 : 4'b0000;
      tick();
      chk("t5_inactive_toggle", o_activity, 1'b0);
    end
    tracedata = 4'b0000;
    repeat (3) tick();
    tracedata = 4'b0001;
    n_high = 0;
    seen = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (o_activity) begin
        n_high++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    chk("t5_stretch_cycles", n_high, (1 << SB) - 1);
    chk("t5_activity_final", o_activity, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
